// File: rtl/iob_reg_file_reader_if.sv
// Output word stream of the register-file burst reader.
// The master drives valid/data/last and the slave drives ready.
interface iob_reg_file_reader_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  m_valid;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_last;
   logic                  m_ready;

   modport master (
      output m_valid,
      output m_data,
      output m_last,
      input  m_ready
   );

   modport slave (
      input  m_valid,
      input  m_data,
      input  m_last,
      output m_ready
   );
endinterface

// File: rtl/iob_reg_file_reader.sv
// Burst read engine for a register file with a combinational read port.
// A command walks len consecutive addresses, wrapping at the top of the
// memory. Each returned word goes into an output register that is held
// under backpressure.
module iob_reg_file_reader #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] start_addr,
   input  logic [LEN_WIDTH-1:0]  len,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] rf_addr,
   input  logic [DATA_WIDTH-1:0] rf_rdata,
   iob_reg_file_reader_if.master m
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_WAIT_LAST
   } state_t;

   state_t                state;
   logic [LEN_WIDTH-1:0]  remaining;
   logic                  m_valid_q;
   logic [DATA_WIDTH-1:0] m_data_q;
   logic                  m_last_q;
   logic                  load;

   // The output register can take a new word when it is empty or being drained.
   assign load = !m_valid_q || m.m_ready;

   // Drive the stream interface from the output register.
   assign m.m_valid = m_valid_q;
   assign m.m_data  = m_data_q;
   assign m.m_last  = m_last_q;

   // Command acceptance, address walk, output register and completion pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         rf_addr   <= '0;
         remaining <= '0;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         m_last_q  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (len != '0) begin
                     rf_addr   <= start_addr;
                     remaining <= len;
                     busy      <= 1'b1;
                     state     <= ST_READ;
                  end else begin
                     // An empty burst completes immediately without leaving IDLE.
                     done <= 1'b1;
                  end
               end
            end

            ST_READ: begin
               if (load) begin
                  m_data_q  <= rf_rdata;
                  m_valid_q <= 1'b1;
                  m_last_q  <= (remaining == LEN_WIDTH'(1));
                  rf_addr   <= rf_addr + 1'b1;
                  remaining <= remaining - 1'b1;
                  if (remaining == LEN_WIDTH'(1)) begin
                     state <= ST_WAIT_LAST;
                  end
               end
            end

            ST_WAIT_LAST: begin
               if (m_valid_q && m.m_ready) begin
                  m_valid_q <= 1'b0;
                  m_last_q  <= 1'b0;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state     <= ST_IDLE;
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_iob_reg_file_reader.sv
// Directed self-checking bench for iob_reg_file_reader with a 1024-word
// register file preloaded with mem[i] = i * 0x01010101.
module tb_iob_reg_file_reader;

   localparam int DW = 32;
   localparam int AW = 10;
   localparam int LW = AW + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] start_addr;
   logic [LW-1:0] len;
   logic          busy;
   logic          done;
   logic [AW-1:0] rf_addr;
   logic [DW-1:0] rf_rdata;
   logic [DW-1:0] mem [0:1023];

   int pass_cnt  = 0;
   int total_cnt = 0;

   iob_reg_file_reader_if #(.DATA_WIDTH(DW)) sif ();

   iob_reg_file_reader #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .LEN_WIDTH (LW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .start_addr(start_addr),
      .len       (len),
      .busy      (busy),
      .done      (done),
      .rf_addr   (rf_addr),
      .rf_rdata  (rf_rdata),
      .m         (sif)
   );

   always #5 clk = ~clk;

   assign rf_rdata = mem[rf_addr];

   function automatic logic [31:0] model(input int unsigned a);
      logic [31:0] av;
      av = 32'(a % 1024);
      return av * 32'h01010101;
   endfunction

   // Stream monitor: records transfers, done pulses and hold-rule violations.
   logic [31:0] q_data [$];
   logic        q_last [$];
   int          done_cnt   = 0;
   int          valid_seen = 0;
   int          hold_viol  = 0;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_data  = '0;
   logic        prev_last  = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && (sif.m_valid !== 1'b1 || sif.m_data !== prev_data ||
                            sif.m_last !== prev_last))
            hold_viol++;
         if (sif.m_valid && sif.m_ready) begin
            q_data.push_back(sif.m_data);
            q_last.push_back(sif.m_last);
         end
         if (done) done_cnt++;
         if (sif.m_valid) valid_seen++;
         prev_stall = sif.m_valid && !sif.m_ready;
         prev_data  = sif.m_data;
         prev_last  = sif.m_last;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      q_data.delete();
      q_last.delete();
      done_cnt   = 0;
      valid_seen = 0;
      hold_viol  = 0;
   endtask

   // Presents a command for one edge; returns 1 ns after the sampling edge.
   task automatic start_burst(input logic [AW-1:0] a, input logic [LW-1:0] l);
      start      = 1'b1;
      start_addr = a;
      len        = l;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int cycles, output bit ok);
      cycles = 0;
      ok     = 1'b0;
      while (cycles < budget) begin
         tick();
         cycles++;
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst        = 1'b1;
      start      = 1'b0;
      start_addr = '0;
      len        = '0;
      sif.m_ready = 1'b0;
      repeat (3) tick();
      total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else pass_cnt++;
      total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else pass_cnt++;
      total_cnt++; if (sif.m_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", sif.m_valid); else pass_cnt++;
      total_cnt++; if (sif.m_last !== 1'b0) $display("FAIL reset_last got %b exp 0", sif.m_last); else pass_cnt++;
      total_cnt++; if (sif.m_data !== 32'h0) $display("FAIL reset_data got %h exp 00000000", sif.m_data); else pass_cnt++;
      total_cnt++; if (rf_addr !== 10'd0) $display("FAIL reset_rf_addr got %0d exp 0", rf_addr); else pass_cnt++;
      rst = 1'b0;
      tick();
      total_cnt++; if ({busy, done, sif.m_valid} !== 3'b000) $display("FAIL reset_release got %b exp 000", {busy, done, sif.m_valid}); else pass_cnt++;
   endtask

   task automatic test_basic();
      logic [31:0] exp_d [3];
      exp_d[0] = 32'h04040404;
      exp_d[1] = 32'h05050505;
      exp_d[2] = 32'h06060606;
      clear_mon();
      sif.m_ready = 1'b1;
      start_burst(10'd4, 11'd3);
      total_cnt++; if ({busy, sif.m_valid} !== 2'b10) $display("FAIL basic_accept got busy,valid=%b exp 10", {busy, sif.m_valid}); else pass_cnt++;
      total_cnt++; if (rf_addr !== 10'd4) $display("FAIL basic_rf_addr got %0d exp 4", rf_addr); else pass_cnt++;
      for (int k = 0; k < 3; k++) begin
         tick();
         total_cnt++;
         if ({busy, done, sif.m_valid, sif.m_last, sif.m_data} !== {1'b1, 1'b0, 1'b1, (k == 2), exp_d[k]})
            $display("FAIL basic_word%0d got busy=%b done=%b valid=%b last=%b data=%h exp busy=1 done=0 valid=1 last=%b data=%h",
                     k, busy, done, sif.m_valid, sif.m_last, sif.m_data, (k == 2), exp_d[k]);
         else pass_cnt++;
      end
      tick();
      total_cnt++; if ({done, busy, sif.m_valid} !== 3'b100) $display("FAIL basic_done got done,busy,valid=%b exp 100", {done, busy, sif.m_valid}); else pass_cnt++;
      tick();
      total_cnt++; if (done !== 1'b0) $display("FAIL basic_done_pulse got %b exp 0", done); else pass_cnt++;
      total_cnt++; if (q_data.size() !== 3) $display("FAIL basic_count got %0d exp 3", q_data.size()); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int cyc;
      bit ok;
      clear_mon();
      sif.m_ready = 1'b1;
      start_burst(10'd50, 11'd1);
      wait_done(20, cyc, ok);
      total_cnt++; if (!ok || cyc != 2) $display("FAIL b2b_first_done got ok=%0d cycles=%0d exp ok=1 cycles=2", ok, cyc); else pass_cnt++;
      // Command presented while done is high is sampled in IDLE.
      start_burst(10'd60, 11'd2);
      total_cnt++; if ({busy, rf_addr} !== {1'b1, 10'd60}) $display("FAIL b2b_accept got busy=%b rf_addr=%0d exp busy=1 rf_addr=60", busy, rf_addr); else pass_cnt++;
      wait_done(20, cyc, ok);
      tick();
      total_cnt++;
      if (q_data.size() !== 3 || q_data[0] !== 32'h32323232 || q_data[1] !== 32'h3C3C3C3C || q_data[2] !== 32'h3D3D3D3D)
         $display("FAIL b2b_data got n=%0d exp n=3 words 32323232 3c3c3c3c 3d3d3d3d", q_data.size());
      else pass_cnt++;
      total_cnt++; if (done_cnt !== 2) $display("FAIL b2b_done_cnt got %0d exp 2", done_cnt); else pass_cnt++;
   endtask

   task automatic test_backpressure();
      clear_mon();
      sif.m_ready = 1'b1;
      start_burst(10'd4, 11'd3);
      tick();
      tick();
      total_cnt++; if (sif.m_data !== 32'h05050505) $display("FAIL bp_word2 got %h exp 05050505", sif.m_data); else pass_cnt++;
      sif.m_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         total_cnt++;
         if ({sif.m_valid, sif.m_last, sif.m_data} !== {1'b1, 1'b0, 32'h05050505})
            $display("FAIL bp_hold%0d got valid=%b last=%b data=%h exp valid=1 last=0 data=05050505",
                     k, sif.m_valid, sif.m_last, sif.m_data);
         else pass_cnt++;
      end
      sif.m_ready = 1'b1;
      tick();
      total_cnt++; if ({sif.m_last, sif.m_data} !== {1'b1, 32'h06060606}) $display("FAIL bp_word3 got last=%b data=%h exp last=1 data=06060606", sif.m_last, sif.m_data); else pass_cnt++;
      tick();
      total_cnt++; if (done !== 1'b1) $display("FAIL bp_done got %b exp 1", done); else pass_cnt++;
      tick();
      total_cnt++;
      if (q_data.size() !== 3 || q_data[0] !== 32'h04040404 || q_data[1] !== 32'h05050505 || q_data[2] !== 32'h06060606)
         $display("FAIL bp_data got n=%0d exp n=3 words 04040404 05050505 06060606", q_data.size());
      else pass_cnt++;
      total_cnt++; if (hold_viol !== 0) $display("FAIL bp_hold_rule got %0d violations exp 0", hold_viol); else pass_cnt++;
   endtask

   task automatic test_wrap();
      int cyc;
      bit ok;
      int unsigned addrs [4];
      int bad;
      addrs[0] = 1022; addrs[1] = 1023; addrs[2] = 0; addrs[3] = 1;
      clear_mon();
      sif.m_ready = 1'b1;
      start_burst(10'd1022, 11'd4);
      wait_done(20, cyc, ok);
      total_cnt++; if (!ok || cyc != 5) $display("FAIL wrap_latency got ok=%0d cycles=%0d exp ok=1 cycles=5", ok, cyc); else pass_cnt++;
      tick();
      total_cnt++; if (q_data.size() !== 4) $display("FAIL wrap_count got %0d exp 4", q_data.size()); else pass_cnt++;
      bad = 0;
      for (int i = 0; i < 4 && i < q_data.size(); i++)
         if (q_data[i] !== model(addrs[i]) || q_last[i] !== (i == 3)) bad++;
      total_cnt++; if (bad !== 0) $display("FAIL wrap_words got %0d bad words exp 0", bad); else pass_cnt++;
   endtask

   task automatic test_toggle();
      logic [15:0] pat;
      int cyc;
      int bad;
      bit ok;
      pat = 16'b1011_0010_0110_1001;
      clear_mon();
      sif.m_ready = 1'b0;
      start_burst(10'd200, 11'd6);
      cyc = 0;
      ok  = 1'b0;
      while (cyc < 80) begin
         sif.m_ready = pat[cyc % 16];
         tick();
         cyc++;
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
      sif.m_ready = 1'b1;
      tick();
      total_cnt++; if (!ok) $display("FAIL toggle_done got timeout after %0d cycles exp done", cyc); else pass_cnt++;
      total_cnt++; if (q_data.size() !== 6) $display("FAIL toggle_count got %0d exp 6", q_data.size()); else pass_cnt++;
      bad = 0;
      for (int i = 0; i < q_data.size(); i++)
         if (q_data[i] !== model(200 + i) || q_last[i] !== (i == 5)) bad++;
      total_cnt++; if (bad !== 0) $display("FAIL toggle_words got %0d bad words exp 0", bad); else pass_cnt++;
      total_cnt++; if (hold_viol !== 0) $display("FAIL toggle_hold_rule got %0d violations exp 0", hold_viol); else pass_cnt++;
   endtask

   task automatic test_zero_len();
      clear_mon();
      sif.m_ready = 1'b1;
      start_burst(10'd5, 11'd0);
      total_cnt++; if ({done, busy, sif.m_valid} !== 3'b100) $display("FAIL zero_done got done,busy,valid=%b exp 100", {done, busy, sif.m_valid}); else pass_cnt++;
      tick();
      total_cnt++; if ({done, busy} !== 2'b00) $display("FAIL zero_after got done,busy=%b exp 00", {done, busy}); else pass_cnt++;
      repeat (4) tick();
      total_cnt++; if (valid_seen !== 0 || q_data.size() !== 0) $display("FAIL zero_no_data got valid_cycles=%0d words=%0d exp 0 0", valid_seen, q_data.size()); else pass_cnt++;
   endtask

   task automatic test_full();
      int cyc;
      int bad;
      bit ok;
      clear_mon();
      sif.m_ready = 1'b1;
      start_burst(10'd0, 11'd1024);
      repeat (100) tick();
      start      = 1'b1;
      start_addr = 10'd7;
      len        = 11'd5;
      tick();
      start = 1'b0;
      wait_done(1200, cyc, ok);
      total_cnt++; if (!ok || (cyc + 101) != 1025) $display("FAIL full_latency got ok=%0d cycles=%0d exp ok=1 cycles=1025", ok, cyc + 101); else pass_cnt++;
      tick();
      total_cnt++; if (q_data.size() !== 1024) $display("FAIL full_count got %0d exp 1024", q_data.size()); else pass_cnt++;
      bad = 0;
      for (int i = 0; i < q_data.size(); i++)
         if (q_data[i] !== model(i) || q_last[i] !== (i == 1023)) bad++;
      total_cnt++; if (bad !== 0) $display("FAIL full_words got %0d bad words exp 0", bad); else pass_cnt++;
      repeat (6) tick();
      total_cnt++; if (done_cnt !== 1 || q_data.size() !== 1024 || busy !== 1'b0)
         $display("FAIL full_ignored_start got done_cnt=%0d words=%0d busy=%b exp 1 1024 0", done_cnt, q_data.size(), busy);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      int cyc;
      bit ok;
      clear_mon();
      sif.m_ready = 1'b1;
      start_burst(10'd10, 11'd8);
      repeat (3) tick();
      rst = 1'b1;
      tick();
      total_cnt++; if ({sif.m_valid, busy, done} !== 3'b000) $display("FAIL rstmid_state got valid,busy,done=%b exp 000", {sif.m_valid, busy, done}); else pass_cnt++;
      rst = 1'b0;
      repeat (3) tick();
      total_cnt++;
      if (q_data.size() !== 2 || q_data[0] !== 32'h0A0A0A0A || q_data[1] !== 32'h0B0B0B0B || done_cnt !== 0 || sif.m_valid !== 1'b0)
         $display("FAIL rstmid_abort got words=%0d done_cnt=%0d valid=%b exp words=2 (0a0a0a0a 0b0b0b0b) done_cnt=0 valid=0",
                  q_data.size(), done_cnt, sif.m_valid);
      else pass_cnt++;
      clear_mon();
      start_burst(10'd30, 11'd2);
      wait_done(20, cyc, ok);
      tick();
      total_cnt++;
      if (!ok || q_data.size() !== 2 || q_data[0] !== 32'h1E1E1E1E || q_data[1] !== 32'h1F1F1F1F ||
          q_last[0] !== 1'b0 || q_last[1] !== 1'b1 || done_cnt !== 1)
         $display("FAIL rstmid_restart got ok=%0d words=%0d done_cnt=%0d exp ok=1 words=2 (1e1e1e1e 1f1f1f1f, last on 2nd) done_cnt=1",
                  ok, q_data.size(), done_cnt);
      else pass_cnt++;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = model(i);
      test_reset();
      test_basic();
      test_back_to_back();
      test_backpressure();
      test_wrap();
      test_toggle();
      test_zero_len();
      test_full();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1);
   end

endmodule
